// File: rtl/awgn_pkg.sv
// -----------------------------------------------------------------------------
// awgn_pkg
// Shared types and widths for the 4-lane AWGN channel sequencer.
//   DATA_W        sample / channel lane width
//   N_LANES       lanes per channel word
//   LANE_IDX_W    width of the lane fill index
//   sched_state_t scheduler FSM states
//   lane_word_t   one 4-lane channel word, lane 1 at index 0
// -----------------------------------------------------------------------------
package awgn_pkg;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned N_LANES    = 4;
  localparam int unsigned LANE_IDX_W = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PACK   = 3'd1,
    ISSUE  = 3'd2,
    DRAIN  = 3'd3,
    SWITCH = 3'd4
  } sched_state_t;

  typedef logic [N_LANES-1:0][DATA_W-1:0] lane_word_t;

endpackage

// File: rtl/awgn_inflight_pipe.sv
// -----------------------------------------------------------------------------
// awgn_inflight_pipe
// Tracks words travelling through the channel: a DEPTH-deep shift register of
// valid bits, each carrying the noisy tag the word was issued with.
//   clk, reset  clock, synchronous active-high reset
//   push        a word is issued to the channel this cycle
//   push_tag    1 = the word is issued with noise enabled
//   tail_valid  the oldest stage holds a word; ch_out is valid for it now
//   tail_tag    noisy tag of that word
//   empty_c     no word in flight (combinational)
// -----------------------------------------------------------------------------
module awgn_inflight_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_tag,
  output logic tail_valid,
  output logic tail_tag,
  output logic empty_c
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] tag_q;

  // Stage 0 takes the new word; every stage shifts one per clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      tag_q   <= '0;
    end else begin
      valid_q[0] <= push;
      tag_q[0]   <= push_tag;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign tail_valid = valid_q[DEPTH-1];
  assign tail_tag   = tag_q[DEPTH-1];
  assign empty_c    = ~|valid_q;

endmodule

// File: rtl/awgn_channel_sched.sv
// -----------------------------------------------------------------------------
// awgn_channel_sched
// Packs a serial sample stream into 4-lane words, issues them to the AWGN
// channel, schedules noise_off in alternating clean/noisy frame windows and
// tags each returned word as valid and clean/noisy.
//   clk, reset                  clock, synchronous active-high reset
//   start                       1-cycle pulse, begins a run from IDLE
//   cfg_clean_frames            clean frames per schedule cycle (0 = never)
//   cfg_noisy_frames            noisy frames per schedule cycle (0 = never)
//   cfg_force_clean             hold noise_off high at frame boundaries
//   s_valid, s_data, s_ready    serial sample input handshake
//   ch_data1..4, ch_noise_off   drive the channel inputs
//   ch_out1..4                  channel outputs
//   m_valid, m_data1..4, m_noisy returned word with noisy tag (1-cycle pulse)
//   busy                        run in progress
//   frame_cnt                   frames completed in this run (wraps)
// -----------------------------------------------------------------------------
module awgn_channel_sched
  import awgn_pkg::*;
#(
  parameter int unsigned CH_LATENCY = 2,
  parameter int unsigned FRAME_LEN  = 64,
  parameter int unsigned CNT_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_clean_frames,
  input  logic [CNT_W-1:0]  cfg_noisy_frames,
  input  logic              cfg_force_clean,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [DATA_W-1:0] ch_data1,
  output logic [DATA_W-1:0] ch_data2,
  output logic [DATA_W-1:0] ch_data3,
  output logic [DATA_W-1:0] ch_data4,
  output logic              ch_noise_off,
  input  logic [DATA_W-1:0] ch_out1,
  input  logic [DATA_W-1:0] ch_out2,
  input  logic [DATA_W-1:0] ch_out3,
  input  logic [DATA_W-1:0] ch_out4,
  output logic              m_valid,
  output logic [DATA_W-1:0] m_data1,
  output logic [DATA_W-1:0] m_data2,
  output logic [DATA_W-1:0] m_data3,
  output logic [DATA_W-1:0] m_data4,
  output logic              m_noisy,
  output logic              busy,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam int unsigned WORD_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  sched_state_t          state_q, state_d;
  logic [LANE_IDX_W-1:0] lane_idx_q, lane_idx_d;
  lane_word_t            lanes_q, lanes_d;
  lane_word_t            ch_word_q, ch_word_d;
  logic [WORD_W-1:0]     word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0]      clean_q, clean_d;
  logic [CNT_W-1:0]      noisy_q, noisy_d;
  logic [CNT_W-1:0]      win_pos_q, win_pos_d;
  logic [CNT_W-1:0]      frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0]      clean_eff;
  logic [CNT_W-1:0]      win_len;
  logic                  noisy_win_q, noisy_win_d;
  logic                  noise_off_q, noise_off_d;
  logic                  s_ready_q, s_ready_d;
  logic                  busy_q, busy_d;
  logic                  push;

  logic                  pipe_tail_valid;
  logic                  pipe_tail_tag;
  logic                  pipe_empty;

  logic                  m_valid_q;
  logic                  m_noisy_q;
  lane_word_t            m_word_q;

  // Words in flight through the channel, with their noisy tags.
  awgn_inflight_pipe #(
    .DEPTH (CH_LATENCY)
  ) u_pipe (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_tag   (~noise_off_q),
    .tail_valid (pipe_tail_valid),
    .tail_tag   (pipe_tail_tag),
    .empty_c    (pipe_empty)
  );

  // Next-state and next register values.
  always_comb begin
    state_d     = state_q;
    lane_idx_d  = lane_idx_q;
    lanes_d     = lanes_q;
    ch_word_d   = ch_word_q;
    word_cnt_d  = word_cnt_q;
    clean_d     = clean_q;
    noisy_d     = noisy_q;
    win_pos_d   = win_pos_q;
    frame_cnt_d = frame_cnt_q;
    noisy_win_d = noisy_win_q;
    noise_off_d = noise_off_q;
    push        = 1'b0;
    clean_eff   = cfg_clean_frames;
    win_len     = noisy_win_q ? noisy_q : clean_q;

    // A schedule with no windows at all degenerates to always clean.
    if ((cfg_clean_frames == '0) && (cfg_noisy_frames == '0)) begin
      clean_eff = CNT_W'(1);
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = PACK;
          clean_d     = clean_eff;
          noisy_d     = cfg_noisy_frames;
          noisy_win_d = (clean_eff == '0);
          win_pos_d   = '0;
          word_cnt_d  = '0;
          lane_idx_d  = '0;
          frame_cnt_d = '0;
          noise_off_d = cfg_force_clean | (clean_eff != '0);
        end
      end

      PACK: begin
        if (s_valid && s_ready_q) begin
          lanes_d[lane_idx_q] = s_data;
          lane_idx_d          = lane_idx_q + LANE_IDX_W'(1);
          // Channel inputs change once per word, on the last lane's accept.
          if (lane_idx_q == LANE_IDX_W'(N_LANES - 1)) begin
            ch_word_d = lanes_d;
            state_d   = ISSUE;
          end
        end
      end

      ISSUE: begin
        push = 1'b1;
        if (word_cnt_q == WORD_W'(FRAME_LEN - 1)) begin
          word_cnt_d = '0;
          state_d    = DRAIN;
        end else begin
          word_cnt_d = word_cnt_q + WORD_W'(1);
          state_d    = PACK;
        end
      end

      // Hold noise_off until every issued word of the frame has returned.
      DRAIN: begin
        if (pipe_empty) begin
          state_d = SWITCH;
        end
      end

      SWITCH: begin
        frame_cnt_d = frame_cnt_q + CNT_W'(1);
        // The active window always has a nonzero length; a zero-length
        // opposite window is skipped by staying in the current one.
        if (win_pos_q == win_len - CNT_W'(1)) begin
          win_pos_d   = '0;
          noisy_win_d = noisy_win_q ? (clean_q == '0) : (noisy_q != '0);
        end else begin
          win_pos_d = win_pos_q + CNT_W'(1);
        end
        noise_off_d = cfg_force_clean | ~noisy_win_d;
        state_d     = PACK;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    s_ready_d = (state_d == PACK);
    busy_d    = (state_d != IDLE);
  end

  // State and datapath registers, plus the channel return path.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      lane_idx_q  <= '0;
      lanes_q     <= '0;
      ch_word_q   <= '0;
      word_cnt_q  <= '0;
      clean_q     <= '0;
      noisy_q     <= '0;
      win_pos_q   <= '0;
      frame_cnt_q <= '0;
      noisy_win_q <= 1'b0;
      noise_off_q <= 1'b1;
      s_ready_q   <= 1'b0;
      busy_q      <= 1'b0;
      m_valid_q   <= 1'b0;
      m_noisy_q   <= 1'b0;
      m_word_q    <= '0;
    end else begin
      state_q     <= state_d;
      lane_idx_q  <= lane_idx_d;
      lanes_q     <= lanes_d;
      ch_word_q   <= ch_word_d;
      word_cnt_q  <= word_cnt_d;
      clean_q     <= clean_d;
      noisy_q     <= noisy_d;
      win_pos_q   <= win_pos_d;
      frame_cnt_q <= frame_cnt_d;
      noisy_win_q <= noisy_win_d;
      noise_off_q <= noise_off_d;
      s_ready_q   <= s_ready_d;
      busy_q      <= busy_d;
      m_valid_q   <= pipe_tail_valid;
      if (pipe_tail_valid) begin
        m_word_q  <= {ch_out4, ch_out3, ch_out2, ch_out1};
        m_noisy_q <= pipe_tail_tag;
      end
    end
  end

  assign s_ready      = s_ready_q;
  assign ch_data1     = ch_word_q[0];
  assign ch_data2     = ch_word_q[1];
  assign ch_data3     = ch_word_q[2];
  assign ch_data4     = ch_word_q[3];
  assign ch_noise_off = noise_off_q;
  assign m_valid      = m_valid_q;
  assign m_data1      = m_word_q[0];
  assign m_data2      = m_word_q[1];
  assign m_data3      = m_word_q[2];
  assign m_data4      = m_word_q[3];
  assign m_noisy      = m_noisy_q;
  assign busy         = busy_q;
  assign frame_cnt    = frame_cnt_q;

endmodule

// File: tb/tb_awgn_channel_sched.sv
// -----------------------------------------------------------------------------
// tb_awgn_channel_sched
// Bench for the AWGN channel sequencer with a behavioural channel model
// (CH_LATENCY register stages, noise = XOR with a fixed mask when enabled)
// and a word-level scoreboard derived from the frame schedule arithmetic.
// -----------------------------------------------------------------------------
module tb_awgn_channel_sched;

  localparam int unsigned DW        = 16;
  localparam int unsigned CH_LAT    = 2;
  localparam int unsigned FRAME_LEN = 2;
  localparam int unsigned CNT_W     = 8;
  localparam logic [DW-1:0] NOISE_MASK = 16'h5A5A;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] cfg_clean_frames;
  logic [CNT_W-1:0] cfg_noisy_frames;
  logic             cfg_force_clean;
  logic             s_valid;
  logic [DW-1:0]    s_data;
  logic             s_ready;
  logic [DW-1:0]    ch_data1, ch_data2, ch_data3, ch_data4;
  logic             ch_noise_off;
  logic [DW-1:0]    ch_out1, ch_out2, ch_out3, ch_out4;
  logic             m_valid;
  logic [DW-1:0]    m_data1, m_data2, m_data3, m_data4;
  logic             m_noisy;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;

  always #5 clk = ~clk;

  awgn_channel_sched #(
    .CH_LATENCY (CH_LAT),
    .FRAME_LEN  (FRAME_LEN),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .cfg_clean_frames (cfg_clean_frames),
    .cfg_noisy_frames (cfg_noisy_frames),
    .cfg_force_clean  (cfg_force_clean),
    .s_valid          (s_valid),
    .s_data           (s_data),
    .s_ready          (s_ready),
    .ch_data1         (ch_data1),
    .ch_data2         (ch_data2),
    .ch_data3         (ch_data3),
    .ch_data4         (ch_data4),
    .ch_noise_off     (ch_noise_off),
    .ch_out1          (ch_out1),
    .ch_out2          (ch_out2),
    .ch_out3          (ch_out3),
    .ch_out4          (ch_out4),
    .m_valid          (m_valid),
    .m_data1          (m_data1),
    .m_data2          (m_data2),
    .m_data3          (m_data3),
    .m_data4          (m_data4),
    .m_noisy          (m_noisy),
    .busy             (busy),
    .frame_cnt        (frame_cnt)
  );

  // Channel model: noise applied when data enters, CH_LAT register stages.
  logic [3:0][DW-1:0] chan_in;
  logic [3:0][DW-1:0] chan_q [CH_LAT];

  assign chan_in = ch_noise_off ? {ch_data4, ch_data3, ch_data2, ch_data1}
                                : {ch_data4 ^ NOISE_MASK, ch_data3 ^ NOISE_MASK,
                                   ch_data2 ^ NOISE_MASK, ch_data1 ^ NOISE_MASK};

  always @(posedge clk) begin
    chan_q[0] <= chan_in;
    for (int i = 1; i < CH_LAT; i++) chan_q[i] <= chan_q[i-1];
  end

  assign ch_out1 = chan_q[CH_LAT-1][0];
  assign ch_out2 = chan_q[CH_LAT-1][1];
  assign ch_out3 = chan_q[CH_LAT-1][2];
  assign ch_out4 = chan_q[CH_LAT-1][3];

  // Scoreboard state.
  typedef struct packed {
    logic [3:0][DW-1:0] d;
    logic               noisy;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] acc[$];
  int            word_idx, ret_idx, mv_cnt;
  logic [7:0]    obs_mask;
  int            run_c, run_n;
  bit            run_force;
  int            pass_cnt  = 0;
  int            total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  // Frame f of a run is noisy when it falls past the clean part of its schedule cycle.
  function automatic bit frame_noisy(input int f);
    int c;
    c = (run_c == 0 && run_n == 0) ? 1 : run_c;
    if (run_force) return 1'b0;
    return (f % (c + run_n)) >= c;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    acc.delete();
    word_idx = 0;
    ret_idx  = 0;
    mv_cnt   = 0;
    obs_mask = '0;
  endtask

  task automatic model_accept(input logic [DW-1:0] d);
    exp_t e;
    acc.push_back(d);
    if (acc.size() == 4) begin
      e.noisy = frame_noisy(word_idx / FRAME_LEN);
      for (int i = 0; i < 4; i++) e.d[i] = acc[i] ^ (e.noisy ? NOISE_MASK : 16'h0000);
      exp_q.push_back(e);
      acc.delete();
      word_idx++;
    end
  endtask

  // Returned-word monitor and noise-change guard.
  initial begin : monitor
    exp_t e;
    logic prev_noff;
    logic [3:0][DW-1:0] got;
    int   fr;
    prev_noff = 1'b1;
    forever begin
      @(negedge clk);
      if (m_valid === 1'b1) begin
        mv_cnt++;
        if (exp_q.size() == 0) begin
          check("unexpected_m_valid", 32'(m_valid), 32'd0);
        end else begin
          e   = exp_q.pop_front();
          got = {m_data4, m_data3, m_data2, m_data1};
          for (int i = 0; i < 4; i++)
            check($sformatf("m_data%0d", i + 1), 32'(got[i]), 32'(e.d[i]));
          check("m_noisy", 32'(m_noisy), 32'(e.noisy));
        end
        fr = ret_idx / FRAME_LEN;
        if (fr < 8) obs_mask[fr] = m_noisy;
        ret_idx++;
      end
      if (reset === 1'b0 && ch_noise_off !== prev_noff)
        check("noise_toggle_inflight", 32'(exp_q.size()), 32'd0);
      prev_noff = ch_noise_off;
    end
  end

  // All tasks below are entered and left 1 time unit after a rising edge.
  task automatic send(input logic [DW-1:0] d);
    int n;
    s_valid = 1'b1;
    s_data  = d;
    n = 0;
    while (!s_ready && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 300) check("s_ready_timeout", 32'(s_ready), 32'd1);
    @(posedge clk);
    model_accept(d);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic start_run(input int c, input int n, input bit f);
    model_clear();
    run_c = c;
    run_n = n;
    run_force = f;
    cfg_clean_frames = CNT_W'(c);
    cfg_noisy_frames = CNT_W'(n);
    cfg_force_clean  = f;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_returns(input int n);
    int k;
    k = 0;
    while (ret_idx < n && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (ret_idx < n) check("return_timeout", 32'(ret_idx), 32'(n));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_noise_off"}, 32'(ch_noise_off), 32'd1);
    check({tag, "_s_ready"},   32'(s_ready),      32'd0);
    check({tag, "_busy"},      32'(busy),         32'd0);
    check({tag, "_m_valid"},   32'(m_valid),      32'd0);
    check({tag, "_ch_data"},   32'({ch_data4, ch_data3}), 32'd0);
    check({tag, "_ch_data_lo"}, 32'({ch_data2, ch_data1}), 32'd0);
    check({tag, "_frame_cnt"}, 32'(frame_cnt),    32'd0);
  endtask

  typedef struct {
    int         clean;
    int         noisy;
    bit         fc;
    int         frames;
    logic [7:0] mask;
  } vec_t;

  vec_t vec[7];

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    logic [DW-1:0] s1, s2, a1, b2;
    logic [3:0][DW-1:0] snap;
    int changed, n;

    // Schedule table: expected noisy flag per frame, frame 0 in bit 0.
    vec[0] = '{clean: 1, noisy: 2, fc: 1'b0, frames: 8, mask: 8'hB6};
    vec[1] = '{clean: 1, noisy: 1, fc: 1'b0, frames: 8, mask: 8'hAA};
    vec[2] = '{clean: 2, noisy: 1, fc: 1'b0, frames: 8, mask: 8'h24};
    vec[3] = '{clean: 0, noisy: 3, fc: 1'b0, frames: 6, mask: 8'h3F};
    vec[4] = '{clean: 0, noisy: 0, fc: 1'b0, frames: 5, mask: 8'h00};
    vec[5] = '{clean: 1, noisy: 2, fc: 1'b1, frames: 6, mask: 8'h00};
    vec[6] = '{clean: 3, noisy: 0, fc: 1'b0, frames: 4, mask: 8'h00};

    reset = 1'b1;
    start = 1'b0;
    s_valid = 1'b0;
    s_data = '0;
    cfg_clean_frames = '0;
    cfg_noisy_frames = '0;
    cfg_force_clean = 1'b0;
    run_c = 1;
    run_n = 0;
    run_force = 1'b0;
    model_clear();

    // Reset then idle.
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("idle");

    // Packing order and return latency; force_clean overrides a noisy-only schedule.
    start_run(0, 1, 1'b1);
    check("busy_run", 32'(busy), 32'd1);
    send(16'h0005); send(16'h0017); send(16'h00d1); send(16'h00c5);
    check("pack_lane1", 32'(ch_data1), 32'h0005);
    check("pack_lane2", 32'(ch_data2), 32'h0017);
    check("pack_lane3", 32'(ch_data3), 32'h00d1);
    check("pack_lane4", 32'(ch_data4), 32'h00c5);
    check("issue_s_ready", 32'(s_ready), 32'd0);
    n = 0;
    while (m_valid !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("word_latency", 32'(n), 32'(CH_LAT + 1));
    repeat (3) @(posedge clk);
    #1;
    check("pack_returned", 32'(ret_idx), 32'd1);

    // Frame schedule table with random sample data.
    for (int t = 0; t < 7; t++) begin
      do_reset();
      start_run(vec[t].clean, vec[t].noisy, vec[t].fc);
      for (int w = 0; w < vec[t].frames * int'(FRAME_LEN); w++)
        for (int k = 0; k < 4; k++) send(DW'($urandom));
      wait_returns(vec[t].frames * int'(FRAME_LEN));
      repeat (10) @(posedge clk);
      #1;
      check($sformatf("frame_cnt_v%0d", t), 32'(frame_cnt), 32'(vec[t].frames));
      check($sformatf("noisy_mask_v%0d", t), 32'(obs_mask), 32'(vec[t].mask));
      check($sformatf("busy_v%0d", t), 32'(busy), 32'd1);
    end

    // Stall mid-word: channel inputs hold, lanes resume in order.
    do_reset();
    start_run(1, 0, 1'b0);
    for (int k = 0; k < 4; k++) send(DW'($urandom));
    s1 = DW'($urandom);
    s2 = DW'($urandom);
    a1 = 16'h00a1;
    b2 = 16'h00b2;
    send(s1);
    send(s2);
    snap = {ch_data4, ch_data3, ch_data2, ch_data1};
    changed = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if ({ch_data4, ch_data3, ch_data2, ch_data1} !== snap) changed++;
    end
    check("stall_hold", 32'(changed), 32'd0);
    check("stall_s_ready", 32'(s_ready), 32'd1);
    send(a1);
    send(b2);
    check("stall_lane1", 32'(ch_data1), 32'(s1));
    check("stall_lane2", 32'(ch_data2), 32'(s2));
    check("stall_lane3", 32'(ch_data3), 32'(a1));
    check("stall_lane4", 32'(ch_data4), 32'(b2));
    wait_returns(2);

    // Reset with a word in flight: outputs return to reset values, word dropped.
    repeat (10) @(posedge clk);
    #1;
    do_reset();
    start_run(1, 1, 1'b0);
    for (int k = 0; k < 4; k++) send(DW'($urandom));
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    check_reset_outputs("midrun");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("dropped_word_m_valid", 32'(mv_cnt), 32'd0);

    // Reset with a partial word: the packed lanes are discarded.
    start_run(1, 0, 1'b0);
    for (int k = 0; k < 3; k++) send(DW'($urandom));
    reset = 1'b1;
    @(posedge clk);
    model_clear();
    #1;
    @(posedge clk); #1;
    reset = 1'b0;
    start_run(1, 0, 1'b0);
    send(16'h1001); send(16'h2002); send(16'h3003); send(16'h4004);
    check("partial_lane1", 32'(ch_data1), 32'h1001);
    check("partial_lane4", 32'(ch_data4), 32'h4004);
    wait_returns(1);
    repeat (5) @(posedge clk);
    #1;
    check("partial_word_count", 32'(mv_cnt), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
